// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths, FSM/owner types and default access budget for mem_port_arb
`ifndef XLEN
`define XLEN 32
`endif
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, IF_BUSY, M_BUSY} state_e;
  typedef enum logic {OWN_IF, OWN_M} owner_e;
  localparam int TIMEOUT_CYC_DEF = 15;
endpackage

// File: rtl/arb_timeout_cnt.sv
// arb_timeout_cnt: counts busy cycles since grant and flags the cycle the access budget runs out
module arb_timeout_cnt #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt_q, cnt_d;
  assign cnt_d = clr ? 8'd0 : en ? cnt_q + 8'd1 : cnt_q;
  assign expired = en & (cnt_q == 8'(LIMIT - 1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_port_arb.sv
// mem_port_arb: arbitrates fetch and M-stage accesses onto one memory bus with a per-access timeout.
// Define MEM_ARB_RR_EN for round-robin ties; otherwise M has fixed priority.
`ifndef XLEN
`define XLEN 32
`endif
module mem_port_arb
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [`XLEN-1:0]  if_addr,
  output logic [`XLEN-1:0]  if_rdata,
  output logic              if_done,
  input  logic              m_req,
  input  logic              m_wr,
  input  logic [`XLEN-1:0]  m_addr,
  input  logic [`XLEN-1:0]  m_wdata,
  output logic [`XLEN-1:0]  m_rdata,
  output logic              m_done,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [`XLEN-1:0]  bus_addr,
  output logic [`XLEN-1:0]  bus_wdata,
  input  logic [`XLEN-1:0]  bus_rdata,
  input  logic              bus_ack,
  output logic              stall_if,
  output logic              stall_m,
  output logic              bus_err
);
  state_e state_q, state_d;
  logic [`XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic wr_q, wr_d, cif_q, cif_d, cm_q, cm_d;
  logic busy, expired, fin, if_ok, m_ok, prio_m, gnt_m, gnt_if;
  assign busy = state_q != IDLE;
`ifdef MEM_ARB_RR_EN
  owner_e last_q, last_d;
  assign prio_m = last_q == OWN_IF;
  assign last_d = gnt_m ? OWN_M : gnt_if ? OWN_IF : last_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_q <= OWN_IF;
    else last_q <= last_d;
`else
  assign prio_m = 1'b1;
`endif
  arb_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_tmo (
    .clk(clk), .rst(rst), .clr(gnt_m | gnt_if), .en(busy), .expired(expired)
  );
  // a requester that just completed sits out one IDLE cycle so the other cannot starve
  always_comb begin
    fin = busy & (bus_ack | expired);
    if_ok = if_req & ~cif_q;
    m_ok = m_req & ~cm_q;
    gnt_m = ~busy & m_ok & (~if_ok | prio_m);
    gnt_if = ~busy & if_ok & ~gnt_m;
    state_d = gnt_m ? M_BUSY : gnt_if ? IF_BUSY : fin ? IDLE : state_q;
    addr_d = gnt_m ? m_addr : gnt_if ? if_addr : addr_q;
    wdata_d = gnt_m ? m_wdata : wdata_q;
    wr_d = gnt_m ? m_wr : gnt_if ? 1'b0 : wr_q;
    if_done = fin & (state_q == IF_BUSY);
    m_done = fin & (state_q == M_BUSY);
    cif_d = if_done;
    cm_d = m_done;
    if_rdata = (if_done & bus_ack) ? bus_rdata : '0;
    m_rdata = (m_done & bus_ack) ? bus_rdata : '0;
    bus_req = busy & (bus_ack | ~expired);
    bus_err = busy & expired & ~bus_ack;
    bus_wr = busy & wr_q;
    bus_addr = addr_q;
    bus_wdata = wdata_q;
    stall_if = if_req & ~if_done;
    stall_m = m_req & ~m_done;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
      cif_q <= 1'b0;
      cm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wr_q <= wr_d;
      cif_q <= cif_d;
      cm_q <= cm_d;
    end
endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: directed stimulus with a cycle-level reference model and literal spot checks
`ifndef XLEN
`define XLEN 32
`endif
module tb_mem_port_arb;
  localparam int TO = 4;
  logic clk, rst, if_req, if_done, m_req, m_wr, m_done, bus_req, bus_wr, bus_ack;
  logic stall_if, stall_m, bus_err, force_ack, resp_ack;
  logic [`XLEN-1:0] if_addr, if_rdata, m_addr, m_wdata, m_rdata, bus_addr, bus_wdata, bus_rdata;
  int checks = 0, failures = 0, lat = 0;
  int own = 0, age = 0, n_own = 0, n_age = 0;
  bit ex_if, ex_m, last_m, c_wr, n_ex_if, n_ex_m, n_last_m, n_c_wr;
  bit busy, ack, tmo, fin, ci, cm, pick_m;
  logic [31:0] c_addr = 0, c_wdata = 0, n_c_addr = 0, n_c_wdata = 0;

  mem_port_arb #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_done(m_done), .bus_req(bus_req), .bus_wr(bus_wr),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stall_if(stall_if), .stall_m(stall_m), .bus_err(bus_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  assign bus_ack = force_ack | resp_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // reference model: one access owner at a time, ack/timeout on its busy-cycle index
  always @(negedge clk) begin
    if (!rst) begin own = 0; age = 0; ex_if = 0; ex_m = 0; last_m = 0; end
    busy = own != 0;
    ack = busy && bus_ack;
    tmo = busy && age == TO && !ack;
    fin = ack || tmo;
    chk("bus_req", bus_req, busy && !tmo);
    chk("bus_err", bus_err, tmo);
    chk("bus_wr", bus_wr, own == 2 && c_wr);
    if (busy) chk("bus_addr", bus_addr, c_addr);
    if (busy && c_wr) chk("bus_wdata", bus_wdata, c_wdata);
    chk("if_done", if_done, fin && own == 1);
    chk("m_done", m_done, fin && own == 2);
    chk("if_rdata", if_rdata, (ack && own == 1) ? bus_rdata : 32'h0);
    chk("m_rdata", m_rdata, (ack && own == 2) ? bus_rdata : 32'h0);
    chk("stall_if", stall_if, if_req && !(fin && own == 1));
    chk("stall_m", stall_m, m_req && !(fin && own == 2));
    n_own = own; n_age = age + 1; n_ex_if = 0; n_ex_m = 0; n_last_m = last_m;
    n_c_addr = c_addr; n_c_wdata = c_wdata; n_c_wr = c_wr;
    if (fin) begin
      n_own = 0; n_ex_if = own == 1; n_ex_m = own == 2;
    end else if (!busy) begin
      ci = if_req && !ex_if;
      cm = m_req && !ex_m;
`ifdef MEM_ARB_RR_EN
      pick_m = cm && (!ci || !last_m);
`else
      pick_m = cm;
`endif
      if (pick_m || ci) begin
        n_own = pick_m ? 2 : 1; n_age = 1; n_last_m = pick_m;
        n_c_addr = pick_m ? m_addr : if_addr; n_c_wr = pick_m && m_wr; n_c_wdata = m_wdata;
      end
    end
  end

  always @(posedge clk)
    if (rst) begin
      own = n_own; age = n_age; ex_if = n_ex_if; ex_m = n_ex_m; last_m = n_last_m;
      c_addr = n_c_addr; c_wdata = n_c_wdata; c_wr = n_c_wr;
    end

  always @(posedge clk) begin
    #1;
    resp_ack = lat != 0 && own != 0 && age == lat;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [5:0] order;
    rst = 1; force_ack = 0; resp_ack = 0;
    if_req = 0; if_addr = 0; m_req = 0; m_wr = 0; m_addr = 0; m_wdata = 0; bus_rdata = 0;
    #1 rst = 0;
    tick; tick;
    @(negedge clk);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_done", {if_done, m_done, bus_err}, 0);
    tick; rst = 1;
    // fetch only, ack on first busy cycle
    tick; if_req = 1; if_addr = 32'h100; lat = 1; bus_rdata = 32'h13;
    @(negedge clk);
    chk("a_stall0", stall_if, 1);
    chk("a_bus_req0", bus_req, 0);
    tick; @(negedge clk);
    chk("a_done", if_done, 1);
    chk("a_rdata", if_rdata, 32'h13);
    chk("a_stall1", stall_if, 0);
    chk("a_addr", bus_addr, 32'h100);
    tick; if_req = 0;
    tick;
    // tie: M store wins, held command, then fetch
    tick; if_req = 1; if_addr = 32'h200; m_req = 1; m_wr = 1; m_addr = 32'h2000;
    m_wdata = 32'hDEADBEEF; lat = 3; bus_rdata = 32'h55;
    tick; @(negedge clk);
    chk("b_wr", bus_wr, 1);
    chk("b_addr1", bus_addr, 32'h2000);
    chk("b_wdata1", bus_wdata, 32'hDEADBEEF);
    tick; @(negedge clk);
    chk("b_addr2", bus_addr, 32'h2000);
    chk("b_wdata2", bus_wdata, 32'hDEADBEEF);
    tick; @(negedge clk);
    chk("b_m_done", m_done, 1);
    chk("b_if_wait", if_done, 0);
    tick; m_req = 0; m_wr = 0;
    tick; @(negedge clk);
    chk("b_if_wr", bus_wr, 0);
    chk("b_if_addr", bus_addr, 32'h200);
    tick; tick; @(negedge clk);
    chk("b_if_done", if_done, 1);
    tick; if_req = 0;
    tick;
    // continuous ties alternate because the just-served requester sits out a cycle
    tick; if_req = 1; m_req = 1; if_addr = 32'h300; m_addr = 32'h3000; lat = 1;
    n = 0; order = 0;
    for (int i = 0; i < 20 && n < 6; i++) begin
      @(negedge clk);
      if (m_done | if_done) begin order = {order[4:0], m_done}; n++; end
      tick;
    end
    if_req = 0; m_req = 0;
    chk("c_order", order, 6'b101010);
    chk("c_count", n, 6);
    tick;
    // M alone, gap, then a fresh tie
    tick; m_req = 1; m_addr = 32'h40;
    tick; tick; m_req = 0;
    tick;
    tick; if_req = 1; m_req = 1; if_addr = 32'h400; m_addr = 32'h44;
    tick; @(negedge clk);
`ifdef MEM_ARB_RR_EN
    chk("d_tie_if", if_done, 1);
    chk("d_tie_m", m_done, 0);
`else
    chk("d_tie_if", if_done, 0);
    chk("d_tie_m", m_done, 1);
`endif
    tick; if_req = 0; m_req = 0;
    tick;
    // timeout with no ack; req drops mid-access but the access runs to abort
    tick; m_req = 1; m_wr = 1; m_addr = 32'h80; m_wdata = 32'h1; lat = 0; bus_rdata = 32'hFFFF;
    tick; tick; m_req = 0; m_wr = 0;
    tick; @(negedge clk);
    chk("e_req3", bus_req, 1);
    chk("e_err3", bus_err, 0);
    tick; @(negedge clk);
    chk("e_done4", m_done, 1);
    chk("e_err4", bus_err, 1);
    chk("e_rdata4", m_rdata, 0);
    chk("e_req4", bus_req, 0);
    tick; @(negedge clk);
    chk("e_idle", bus_req, 0);
    // ack coinciding with timeout is a normal completion
    tick; if_req = 1; if_addr = 32'h500; lat = 4; bus_rdata = 32'hAB;
    tick; tick; tick; tick; @(negedge clk);
    chk("f_done", if_done, 1);
    chk("f_err", bus_err, 0);
    chk("f_rdata", if_rdata, 32'hAB);
    tick; if_req = 0;
    // stray ack while idle
    tick; force_ack = 1;
    @(negedge clk);
    chk("g_done", {if_done, m_done, bus_err}, 0);
    tick; force_ack = 0;
    tick;
    // reset during M busy
    tick; m_req = 1; m_addr = 32'h90; lat = 0;
    tick; #2;
    chk("h_req_pre", bus_req, 1);
    rst = 0; #1;
    chk("h_req_rst", bus_req, 0);
    chk("h_done_rst", m_done, 0);
    tick; rst = 1; m_req = 0;
    @(negedge clk);
    chk("h_idle", bus_req, 0);
    tick; tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
